// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one fixed-latency, untagged divider between NUM_REQ requesters.
// Optional DIVARB_STATS_EN adds saturating issue / divide-by-zero counters.
module divider_arbiter_lane #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] dividend_out,
  output logic [WIDTH-1:0] divisor_out,
  output logic             div0_out
);
  assign dividend_out = dividend_in;
  assign divisor_out  = divisor_in;
  assign div0_out     = (divisor_in == '0);
endmodule

module divider_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int DIV_LATENCY = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_valid_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_valid_in,
  output logic [NUM_REQ-1:0]       res_valid_out,
  output logic [WIDTH-1:0]         res_quotient_out,
  output logic [WIDTH-1:0]         res_remainder_out,
  output logic                     res_error_out,
  output logic                     busy_out,
  output logic                     proto_err_out
`ifdef DIVARB_STATS_EN
  ,
  output logic [15:0]              stat_issued_out,
  output logic [15:0]              stat_div0_out
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DIV_LATENCY + 2);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DIV_LATENCY + 1);

  typedef struct packed {
    logic [IW-1:0]    id;
    logic             err;
    logic [WIDTH-1:0] dividend;
  } tag_t;

  typedef enum logic {S_DRAIN, S_RUN} state_t;

  state_t                          state;
  logic [CW-1:0]                   drain_cnt;
  logic [IW-1:0]                   rr_ptr;
  logic [DIV_LATENCY:0]            vld_pipe;
  tag_t [DIV_LATENCY:0]            tag_pipe;
  tag_t                            issue_tag;
  tag_t                            tail;

  logic [NUM_REQ-1:0][WIDTH-1:0]   lane_dvd;
  logic [NUM_REQ-1:0][WIDTH-1:0]   lane_dvs;
  logic [NUM_REQ-1:0]              lane_div0;

  logic                            running;
  logic [NUM_REQ-1:0]              gnt;
  logic [IW-1:0]                   gnt_id, id_hi, id_lo;
  logic                            hit_hi, hit_lo, xfer;
  logic                            tail_v, retire, expect_div;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      divider_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
        .dividend_in  (req_dividend_in[g*WIDTH +: WIDTH]),
        .divisor_in   (req_divisor_in[g*WIDTH +: WIDTH]),
        .dividend_out (lane_dvd[g]),
        .divisor_out  (lane_dvs[g]),
        .div0_out     (lane_div0[g])
      );
    end
  endgenerate

  assign running = (state == S_RUN);

  // Lowest valid index at/above the pointer wins, else lowest valid below it.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    id_hi  = '0;
    id_lo  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_in[i]) begin
        if (IW'(i) >= rr_ptr) begin
          hit_hi = 1'b1;
          id_hi  = IW'(i);
        end else begin
          hit_lo = 1'b1;
          id_lo  = IW'(i);
        end
      end
    end
    gnt_id = hit_hi ? id_hi : id_lo;
    gnt    = '0;
    if (running && (hit_hi || hit_lo)) gnt[gnt_id] = 1'b1;
  end

  assign req_ready_out = gnt;
  assign xfer          = |gnt;

  always_comb begin
    issue_tag.id       = gnt_id;
    issue_tag.err      = lane_div0[gnt_id];
    issue_tag.dividend = lane_dvd[gnt_id];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_DRAIN;
      drain_cnt <= DRAIN_LOAD;
      rr_ptr    <= '0;
    end else begin
      case (state)
        S_DRAIN: begin
          drain_cnt <= drain_cnt - CW'(1);
          if (drain_cnt == CW'(1)) state <= S_RUN;
        end
        S_RUN: begin
          if (xfer) rr_ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + IW'(1);
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_valid_out    <= 1'b0;
      div_dividend_out <= '0;
      div_divisor_out  <= '0;
      vld_pipe         <= '0;
    end else begin
      div_valid_out <= xfer && !lane_div0[gnt_id];
      if (xfer) begin
        div_dividend_out <= lane_dvd[gnt_id];
        div_divisor_out  <= lane_dvs[gnt_id];
      end
      vld_pipe <= {vld_pipe[DIV_LATENCY-1:0], xfer};
    end
  end

  // Tag payload is qualified by vld_pipe, so it needs no reset.
  always_ff @(posedge clk_in) begin
    tag_pipe <= {tag_pipe[DIV_LATENCY-1:0], issue_tag};
  end

  assign tail       = tag_pipe[DIV_LATENCY];
  assign tail_v     = vld_pipe[DIV_LATENCY];
  assign retire     = running && tail_v;
  assign expect_div = tail_v && !tail.err;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      res_valid_out     <= '0;
      res_quotient_out  <= '0;
      res_remainder_out <= '0;
      res_error_out     <= 1'b0;
      proto_err_out     <= 1'b0;
    end else begin
      res_valid_out     <= '0;
      res_quotient_out  <= '0;
      res_remainder_out <= '0;
      res_error_out     <= 1'b0;
      if (retire) begin
        res_valid_out <= NUM_REQ'(1) << tail.id;
        if (tail.err) begin
          res_quotient_out  <= '1;
          res_remainder_out <= tail.dividend;
          res_error_out     <= 1'b1;
        end else begin
          res_quotient_out  <= div_quotient_in;
          res_remainder_out <= div_remainder_in;
        end
      end
      if (running && (div_valid_in != expect_div)) proto_err_out <= 1'b1;
    end
  end

  assign busy_out = !running || (|vld_pipe);

`ifdef DIVARB_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_issued_out <= '0;
      stat_div0_out   <= '0;
    end else if (xfer) begin
      if (stat_issued_out != 16'hFFFF) stat_issued_out <= stat_issued_out + 16'd1;
      if (lane_div0[gnt_id] && stat_div0_out != 16'hFFFF) stat_div0_out <= stat_div0_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// Randomized bench for divider_arbiter with a behavioural divider and a transaction-level scoreboard.
module tb_divider_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int DL = 16;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic [N-1:0]     req_valid_in = '0;
  logic [N*W-1:0]   req_dividend_in = '0;
  logic [N*W-1:0]   req_divisor_in = '0;
  logic [N-1:0]     req_ready_out;
  logic [W-1:0]     div_dividend_out, div_divisor_out;
  logic             div_valid_out;
  logic [W-1:0]     div_quotient_in, div_remainder_in;
  logic             div_valid_in;
  logic [N-1:0]     res_valid_out;
  logic [W-1:0]     res_quotient_out, res_remainder_out;
  logic             res_error_out, busy_out, proto_err_out;
  logic             spur = 1'b0;
`ifdef DIVARB_STATS_EN
  logic [15:0]      stat_issued_out, stat_div0_out;
`endif

  always #5 clk_in = ~clk_in;

  divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .DIV_LATENCY(DL)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_valid_in      (req_valid_in),
    .req_dividend_in   (req_dividend_in),
    .req_divisor_in    (req_divisor_in),
    .req_ready_out     (req_ready_out),
    .div_dividend_out  (div_dividend_out),
    .div_divisor_out   (div_divisor_out),
    .div_valid_out     (div_valid_out),
    .div_quotient_in   (div_quotient_in),
    .div_remainder_in  (div_remainder_in),
    .div_valid_in      (div_valid_in),
    .res_valid_out     (res_valid_out),
    .res_quotient_out  (res_quotient_out),
    .res_remainder_out (res_remainder_out),
    .res_error_out     (res_error_out),
    .busy_out          (busy_out),
    .proto_err_out     (proto_err_out)
`ifdef DIVARB_STATS_EN
    ,
    .stat_issued_out   (stat_issued_out),
    .stat_div0_out     (stat_div0_out)
`endif
  );

  // External divider: fixed latency, no reset, keeps stale contents across DUT reset.
  logic         dv_v [DL];
  logic [W-1:0] dv_q [DL];
  logic [W-1:0] dv_r [DL];
  always @(posedge clk_in) begin
    for (int s = DL - 1; s > 0; s--) begin
      dv_v[s] <= dv_v[s-1];
      dv_q[s] <= dv_q[s-1];
      dv_r[s] <= dv_r[s-1];
    end
    dv_v[0] <= div_valid_out;
    dv_q[0] <= (div_divisor_out != 0) ? div_dividend_out / div_divisor_out : '1;
    dv_r[0] <= (div_divisor_out != 0) ? div_dividend_out % div_divisor_out : '0;
  end
  assign div_valid_in     = dv_v[DL-1] | spur;
  assign div_quotient_in  = dv_q[DL-1];
  assign div_remainder_in = dv_r[DL-1];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: one entry per accepted transfer, ordered by due cycle.
  typedef struct {
    int           issue;
    int           due;
    int           id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
  } exp_t;
  exp_t sbq[$];

  int           cyc = 0, since = 0, mptr = 0, m_win, m_idx;
  logic         m_run, m_hit, m_busy, exp_proto = 1'b0, exp_dv = 1'b0;
  logic [N-1:0] m_rdy;
  logic [W-1:0] exp_dd, exp_ds, m_a, m_b;
  exp_t         m_e;

  always @(negedge clk_in) begin
    cyc++;
    if (rst_in) begin
      since = 0; sbq.delete(); mptr = 0; exp_proto = 1'b0; exp_dv = 1'b0;
    end else begin
      since++;
      m_run = (since > DL + 1);
      m_rdy = '0; m_hit = 1'b0; m_win = 0;
      if (m_run) begin
        for (int k = 0; k < N; k++) begin
          m_idx = (mptr + k) % N;
          if (!m_hit && req_valid_in[m_idx]) begin
            m_hit = 1'b1; m_win = m_idx; m_rdy[m_idx] = 1'b1;
          end
        end
      end
      chk("ready", req_ready_out, m_rdy);
      m_busy = !m_run;
      foreach (sbq[j]) if (sbq[j].issue < cyc && sbq[j].due > cyc) m_busy = 1'b1;
      chk("busy", busy_out, m_busy);
      chk("div_vld", div_valid_out, exp_dv);
      if (exp_dv) begin
        chk("div_dvd", div_dividend_out, exp_dd);
        chk("div_dvs", div_divisor_out, exp_ds);
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        m_e = sbq.pop_front();
        chk("res_vld", res_valid_out, N'(1) << m_e.id);
        chk("res_q", res_quotient_out, m_e.q);
        chk("res_r", res_remainder_out, m_e.r);
        chk("res_err", res_error_out, m_e.e);
      end else begin
        chk("res_vld_idle", res_valid_out, 0);
        chk("res_q_idle", res_quotient_out, 0);
        chk("res_r_idle", res_remainder_out, 0);
        chk("res_err_idle", res_error_out, 0);
      end
      chk("proto", proto_err_out, exp_proto);
      if (m_run && spur) exp_proto = 1'b1;
      exp_dv = 1'b0;
      if (m_hit) begin
        m_a = req_dividend_in[m_win*W +: W];
        m_b = req_divisor_in[m_win*W +: W];
        m_e.issue = cyc; m_e.due = cyc + DL + 2; m_e.id = m_win;
        m_e.e = (m_b == 0);
        m_e.q = m_e.e ? '1  : m_a / m_b;
        m_e.r = m_e.e ? m_a : m_a % m_b;
        sbq.push_back(m_e);
        exp_dv = !m_e.e; exp_dd = m_a; exp_ds = m_b;
        mptr = (m_win + 1) % N;
      end
    end
  end

  // Stimulus state
  logic [N-1:0]        p_v = '0;
  logic [N-1:0][W-1:0] p_a, p_b;
  logic                rst_v = 1'b1, spur_nxt = 1'b0;
  int                  acc_id[$];

  task automatic tick();
    @(posedge clk_in); #1;
    rst_in = rst_v; spur = spur_nxt; req_valid_in = p_v;
    for (int i = 0; i < N; i++) begin
      req_dividend_in[i*W +: W] = p_a[i];
      req_divisor_in[i*W +: W]  = p_b[i];
    end
    @(negedge clk_in);
    for (int i = 0; i < N; i++)
      if (p_v[i] && req_ready_out[i] && !rst_in) begin
        p_v[i] = 1'b0; acc_id.push_back(i);
      end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    p_v[i] = 1'b1; p_a[i] = a; p_b[i] = b;
  endtask

  task automatic rand_op(input int i);
    logic [W-1:0] a, b;
    a = $urandom;
    case ($urandom_range(0, 7))
      0: b = 0;
      1: b = 1;
      2: b = $urandom_range(2, 15);
      3: b = a;
      default: b = $urandom >> $urandom_range(0, 31);
    endcase
    set_op(i, a, b);
  endtask

  task automatic wait_accept(input string tag, input int budget);
    int n = 0;
    while (p_v != 0 && n < budget) begin tick(); n++; end
    chk(tag, p_v, 0);
  endtask

  task automatic do_reset();
    rst_v = 1'b1; p_v = '0; spur_nxt = 1'b0;
    repeat (3) tick();
    chk("rst_ready", req_ready_out, 0);
    chk("rst_res_vld", res_valid_out, 0);
    chk("rst_div_vld", div_valid_out, 0);
    chk("rst_busy", busy_out, 1);
    chk("rst_proto", proto_err_out, 0);
    chk("rst_res_q", res_quotient_out, 0);
    rst_v = 1'b0;
  endtask

  initial begin
    p_a = '0; p_b = '0;
    do_reset();

    // Request pending through the drain window; granted only afterwards.
    set_op(0, 100, 7);
    wait_accept("t1_accept", 40);
    repeat (22) tick();

    // Four requesters continuously valid from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) rand_op(i);
    acc_id.delete();
    for (int n = 0; n < 60 && acc_id.size() < 8; n++) begin
      tick();
      for (int i = 0; i < N; i++) if (!p_v[i]) rand_op(i);
    end
    p_v = '0;
    chk("t2_count", acc_id.size(), 8);
    for (int k = 0; k < 8 && k < acc_id.size(); k++) chk("t2_gnt", acc_id[k], k % N);
    repeat (22) tick();

    // Divide-by-zero sandwiched between normal requests.
    set_op(1, 1000, 3); set_op(2, 55, 0); set_op(3, 77, 11);
    wait_accept("t3_accept", 10);
    set_op(0, 32'hFFFF_FFFF, 1); set_op(1, 0, 5);
    wait_accept("t4_accept", 10);
    repeat (22) tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) if (!p_v[i] && $urandom_range(0, 1)) rand_op(i);
      tick();
    end
    p_v = '0;
    repeat (22) tick();

    // Reset with ops in flight: nothing must come back.
    for (int n = 0; n < 40 && sbq.size() < 10; n++) begin
      for (int i = 0; i < N; i++) if (!p_v[i]) rand_op(i);
      tick();
    end
    chk("t5_inflight", sbq.size() >= 10, 1);
    do_reset();
    repeat (40) tick();

    // Spurious divider valid against an empty tail.
    spur_nxt = 1'b1; tick(); spur_nxt = 1'b0;
    repeat (4) tick();
    chk("proto_sticky", proto_err_out, 1);
    set_op(2, 9, 4);
    wait_accept("t6_accept", 5);
    repeat (22) tick();
    chk("proto_hold", proto_err_out, 1);
    do_reset();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
